// File: rtl/pwm_status_tx.sv
// PWM status transmitter: shadows per-channel PWM config and streams
// it as a UDP status frame on request or on a periodic timer.
module pwm_status_tx #(
  parameter logic [7:0]  ID_PWM_STATUS = 8'd1,
  parameter int unsigned NUM_CH        = 8,
  parameter int unsigned CLK_FREQ      = 100000000,
  parameter int unsigned REPORT_MS     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_config_vld,
  input  logic [7:0]  pwm_config_channel,
  input  logic        pwm_en,
  input  logic [27:0] pwm_period,
  input  logic [27:0] pwm_hlevel,
  input  logic        report_req,
  output logic [31:0] tx_axis_udp_tdata,
  output logic        tx_axis_udp_tvalid,
  output logic        tx_axis_udp_tlast,
  output logic [7:0]  tx_axis_udp_tuser,
  input  logic        tx_axis_udp_tready,
  output logic        busy
);

  localparam int unsigned CW =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] TERM =
    32'((CLK_FREQ / 1000) * REPORT_MS);
  localparam logic [8:0] NCH  = 9'(NUM_CH);
  localparam logic [7:0] LAST = 8'(NUM_CH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]  state;
  logic        tbl_en  [NUM_CH];
  logic [27:0] tbl_per [NUM_CH];
  logic [27:0] tbl_hl  [NUM_CH];

  logic [31:0] tmr;
  logic        tick;
  logic        pending;
  logic [15:0] seq;
  logic [7:0]  ch;
  logic [2:0]  widx;
  logic        rec_en;
  logic [27:0] rec_per;
  logic [27:0] rec_hl;
  logic        vld;
  logic        xfer;
  logic        rec_end;
  logic        wr_ok;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] rd_idx;
  logic [31:0] word;

  assign wr_ok  = ({1'b0, pwm_config_channel} < NCH);
  assign wr_idx = pwm_config_channel[CW-1:0];
  assign rd_idx = ch[CW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        tbl_en[i]  <= 1'b0;
        tbl_per[i] <= 28'd0;
        tbl_hl[i]  <= 28'd0;
      end
    end else if (pwm_config_vld && wr_ok) begin
      tbl_en[wr_idx]  <= pwm_en;
      tbl_per[wr_idx] <= pwm_period;
      tbl_hl[wr_idx]  <= pwm_hlevel;
    end
  end

  // TERM == 0 parks the timer and never ticks
  assign tick = (TERM != 32'd0) && (tmr == TERM - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= 32'd0;
    end else if (tick) begin
      tmr <= 32'd0;
    end else if (TERM != 32'd0) begin
      tmr <= tmr + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (report_req || tick) begin
      pending <= 1'b1;
    end else if (state == S_IDLE) begin
      pending <= 1'b0;
    end
  end

  assign xfer    = vld && tx_axis_udp_tready;
  assign rec_end = xfer && (widx == 3'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ch      <= 8'd0;
      widx    <= 3'd0;
      vld     <= 1'b0;
      rec_en  <= 1'b0;
      rec_per <= 28'd0;
      rec_hl  <= 28'd0;
      seq     <= 16'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pending) begin
            state <= S_LOAD;
            ch    <= 8'd0;
            widx  <= 3'd0;
          end
        end
        S_LOAD: begin
          rec_en  <= tbl_en[rd_idx];
          rec_per <= tbl_per[rd_idx];
          rec_hl  <= tbl_hl[rd_idx];
          widx    <= 3'd0;
          vld     <= 1'b1;
          state   <= S_SEND;
        end
        S_SEND: begin
          if (rec_end) begin
            vld  <= 1'b0;
            widx <= 3'd0;
            if (ch == LAST) begin
              state <= S_IDLE;
              seq   <= seq + 16'd1;
            end else begin
              ch    <= ch + 8'd1;
              state <= S_LOAD;
            end
          end else if (xfer) begin
            widx <= widx + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    word = 32'd0;
    unique case (widx)
      3'd0:    word = {24'd0, ch};
      3'd1:    word = {4'd0, rec_per};
      3'd2:    word = {4'd0, rec_hl};
      3'd3:    word = {16'd0, seq};
      3'd4:    word = {31'd0, rec_en};
      default: word = 32'd0;
    endcase
  end

  assign tx_axis_udp_tvalid = vld;
  assign tx_axis_udp_tdata  = vld ? word : 32'd0;
  assign tx_axis_udp_tuser  = vld ? ID_PWM_STATUS : 8'd0;
  assign tx_axis_udp_tlast  =
    vld && (widx == 3'd4) && (ch == LAST);
  assign busy = pending || (state != S_IDLE);

endmodule

// File: tb/tb_pwm_status_tx.sv
// Directed bench for pwm_status_tx: frame content, backpressure,
// coalescing, periodic timer, LOAD-cycle write, async reset.
module tb_pwm_status_tx;

  localparam int NCH = 8;
  localparam int FW  = 5 * NCH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, vld_a, en_a, req_a, rdy_a;
  logic [7:0]  ch_a;
  logic [27:0] per_a, hl_a;
  logic [31:0] td_a;
  logic        tv_a, tl_a, busy_a;
  logic [7:0]  tu_a;

  logic        rst_b, vld_b, en_b, req_b, rdy_b;
  logic [7:0]  ch_b;
  logic [27:0] per_b, hl_b;
  logic [31:0] td_b;
  logic        tv_b, tl_b, busy_b;
  logic [7:0]  tu_b;

  pwm_status_tx #(
    .ID_PWM_STATUS(8'd1), .NUM_CH(NCH),
    .CLK_FREQ(1000000), .REPORT_MS(1)
  ) dut_a (
    .clk(clk), .rst(rst_a),
    .pwm_config_vld(vld_a), .pwm_config_channel(ch_a),
    .pwm_en(en_a), .pwm_period(per_a), .pwm_hlevel(hl_a),
    .report_req(req_a),
    .tx_axis_udp_tdata(td_a), .tx_axis_udp_tvalid(tv_a),
    .tx_axis_udp_tlast(tl_a), .tx_axis_udp_tuser(tu_a),
    .tx_axis_udp_tready(rdy_a), .busy(busy_a)
  );

  pwm_status_tx #(
    .ID_PWM_STATUS(8'd1), .NUM_CH(NCH),
    .CLK_FREQ(100000), .REPORT_MS(1)
  ) dut_b (
    .clk(clk), .rst(rst_b),
    .pwm_config_vld(vld_b), .pwm_config_channel(ch_b),
    .pwm_en(en_b), .pwm_period(per_b), .pwm_hlevel(hl_b),
    .report_req(req_b),
    .tx_axis_udp_tdata(td_b), .tx_axis_udp_tvalid(tv_b),
    .tx_axis_udp_tlast(tl_b), .tx_axis_udp_tuser(tu_b),
    .tx_axis_udp_tready(rdy_b), .busy(busy_b)
  );

  typedef struct {
    logic [7:0]  ch;
    logic        en;
    logic [27:0] per;
    logic [27:0] hl;
    logic        lands;
  } wr_t;

  typedef struct {
    int          idx;
    logic [31:0] d;
    logic        l;
  } spot_t;

  wr_t   wv [5];
  spot_t sp [9];

  int total = 0;
  int bad   = 0;

  logic        m_en  [NCH];
  logic [27:0] m_per [NCH];
  logic [27:0] m_hl  [NCH];

  logic [31:0] got_d [FW];
  logic        got_l [FW];
  logic [7:0]  got_u [FW];
  int          nw;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_en[i]  = 1'b0;
      m_per[i] = 28'd0;
      m_hl[i]  = 28'd0;
    end
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    vld_a = 1'b0; en_a = 1'b0; req_a = 1'b0; rdy_a = 1'b0;
    ch_a = 8'd0; per_a = 28'd0; hl_a = 28'd0;
    step();
    step();
    chk("reset outputs",
        64'({td_a, tv_a, tl_a, tu_a, busy_a}), 64'd0);
    rst_a = 1'b0;
    model_clear();
  endtask

  task automatic write_cfg(input wr_t v);
    vld_a = 1'b1;
    ch_a  = v.ch;
    en_a  = v.en;
    per_a = v.per;
    hl_a  = v.hl;
    step();
    vld_a = 1'b0;
    if (v.lands) begin
      m_en[v.ch]  = v.en;
      m_per[v.ch] = v.per;
      m_hl[v.ch]  = v.hl;
    end
  endtask

  task automatic pulse_req();
    req_a = 1'b1;
    step();
    req_a = 1'b0;
  endtask

  task automatic run_frame(input int stall_pct, input int bound);
    logic        stalled, done, pl;
    logic [31:0] pd;
    logic [7:0]  pu;
    for (int i = 0; i < FW; i++) begin
      got_d[i] = 32'd0;
      got_l[i] = 1'b0;
      got_u[i] = 8'd0;
    end
    nw = 0;
    stalled = 1'b0;
    done = 1'b0;
    pl = 1'b0;
    pd = 32'd0;
    pu = 8'd0;
    for (int c = 0; c < bound && !done; c++) begin
      if (stalled)
        chk($sformatf("stall hold w%0d", nw),
            64'({tv_a, tl_a, tu_a, td_a}),
            64'({1'b1, pl, pu, pd}));
      rdy_a = ($urandom_range(99) >= stall_pct);
      stalled = tv_a && !rdy_a;
      pd = td_a;
      pl = tl_a;
      pu = tu_a;
      if (tv_a && rdy_a) begin
        if (nw < FW) begin
          got_d[nw] = td_a;
          got_l[nw] = tl_a;
          got_u[nw] = tu_a;
        end
        nw++;
        if (tl_a) done = 1'b1;
      end
      step();
    end
    chk("frame completed", 64'(done), 64'd1);
  endtask

  task automatic check_frame(input string name,
                             input logic [15:0] seq);
    int c, w;
    logic [31:0] ed;
    chk($sformatf("%s word count", name), 64'(nw), 64'(FW));
    for (int i = 0; i < FW; i++) begin
      c = i / 5;
      w = i % 5;
      case (w)
        0:       ed = 32'(c);
        1:       ed = {4'd0, m_per[c]};
        2:       ed = {4'd0, m_hl[c]};
        3:       ed = {16'd0, seq};
        default: ed = {31'd0, m_en[c]};
      endcase
      chk($sformatf("%s w%0d", name, i),
          64'({got_l[i], got_u[i], got_d[i]}),
          64'({(i == FW - 1), 8'd1, ed}));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ok;
    int   starts [3];
    logic [15:0] seqs [3];
    int   wcnt, nf;

    wv[0] = '{8'd3, 1'b1, 28'd100000, 28'd25000, 1'b1};
    wv[1] = '{8'd0, 1'b1, 28'd500, 28'd250, 1'b1};
    wv[2] = '{8'd1, 1'b0, 28'd1000, 28'd10, 1'b1};
    wv[3] = '{8'd9, 1'b1, 28'hABCDE, 28'h1234, 1'b0};
    wv[4] = '{8'd7, 1'b1, 28'hFFFFFFF, 28'hFFFFFFF, 1'b1};

    sp[0] = '{0,  32'd0,      1'b0};
    sp[1] = '{3,  32'd0,      1'b0};
    sp[2] = '{15, 32'd3,      1'b0};
    sp[3] = '{16, 32'd100000, 1'b0};
    sp[4] = '{17, 32'd25000,  1'b0};
    sp[5] = '{18, 32'd0,      1'b0};
    sp[6] = '{19, 32'd1,      1'b0};
    sp[7] = '{35, 32'd7,      1'b0};
    sp[8] = '{39, 32'd0,      1'b1};

    rst_b = 1'b1;
    vld_b = 1'b0; en_b = 1'b0; req_b = 1'b0; rdy_b = 1'b1;
    ch_b = 8'd0; per_b = 28'd0; hl_b = 28'd0;

    // scenario 1: single entry, latency, frame layout
    reset_a();
    write_cfg(wv[0]);
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    chk("s1 edge1 tv/busy", 64'({tv_a, busy_a}), 64'b01);
    step();
    chk("s1 edge2 tv", 64'(tv_a), 64'd0);
    step();
    chk("s1 edge3 tv", 64'(tv_a), 64'd1);
    run_frame(0, 200);
    check_frame("s1", 16'd0);
    for (int k = 0; k < 9; k++)
      chk($sformatf("s1 spot w%0d", sp[k].idx),
          64'({got_l[sp[k].idx], got_d[sp[k].idx]}),
          64'({sp[k].l, sp[k].d}));
    chk("s1 idle after", 64'({tv_a, busy_a, tu_a}), 64'd0);

    // scenario 2: random backpressure
    pulse_req();
    run_frame(50, 800);
    check_frame("s2", 16'd1);

    // scenario 3: requests and a timer tick coalesce during a frame
    reset_a();
    pulse_req();
    for (int c = 0; c < 10 && !tv_a; c++) step();
    chk("s3 frame started", 64'(tv_a), 64'd1);
    ok = 1'b1;
    for (int c = 0; c < 1100; c++) begin
      req_a = (c == 200 || c == 600);
      step();
      if (!tv_a || td_a != 32'd0 || tu_a != 8'd1) ok = 1'b0;
    end
    req_a = 1'b0;
    chk("s3 long stall hold", 64'(ok), 64'd1);
    chk("s3 busy in stall", 64'(busy_a), 64'd1);
    run_frame(0, 200);
    check_frame("s3 f0", 16'd0);
    run_frame(0, 200);
    check_frame("s3 f1", 16'd1);
    ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (tv_a || busy_a) ok = 1'b0;
      step();
    end
    chk("s3 no extra frame", 64'(ok), 64'd1);

    // scenario 5: write in the LOAD cycle, out-of-range channel
    reset_a();
    for (int k = 1; k < 5; k++) write_cfg(wv[k]);
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    step();
    chk("s5 load tv", 64'(tv_a), 64'd0);
    vld_a = 1'b1;
    ch_a  = 8'd0;
    en_a  = 1'b0;
    per_a = 28'd777;
    hl_a  = 28'd333;
    step();
    vld_a = 1'b0;
    chk("s5 send tv", 64'(tv_a), 64'd1);
    run_frame(0, 200);
    check_frame("s5 old", 16'd0);
    m_en[0]  = 1'b0;
    m_per[0] = 28'd777;
    m_hl[0]  = 28'd333;
    pulse_req();
    run_frame(0, 200);
    check_frame("s5 new", 16'd1);

    // scenario 6: reset in the middle of a frame
    rdy_a = 1'b1;
    pulse_req();
    repeat (15) step();
    chk("s6 mid-frame tv", 64'(tv_a), 64'd1);
    #2;
    rst_a = 1'b1;
    #1;
    chk("s6 async drop",
        64'({tv_a, tl_a, tu_a, td_a, busy_a}), 64'd0);
    step();
    step();
    rst_a = 1'b0;
    model_clear();
    pulse_req();
    run_frame(0, 200);
    check_frame("s6", 16'd0);

    // scenario 4: periodic timer on dut_b, 100-cycle interval
    chk("s4 reset outputs",
        64'({td_b, tv_b, tl_b, tu_b, busy_b}), 64'd0);
    rst_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      starts[k] = -1;
      seqs[k] = 16'hDEAD;
    end
    wcnt = 0;
    nf = 0;
    for (int n = 1; n <= 330; n++) begin
      step();
      if (tv_b) begin
        if (wcnt % FW == 0 && nf < 3) starts[nf] = n;
        if (wcnt % FW == 3 && nf < 3) seqs[nf] = td_b[15:0];
        if (tl_b) nf++;
        wcnt++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("s4 start f%0d", k),
          64'(starts[k]), 64'(102 + 100 * k));
      chk($sformatf("s4 seq f%0d", k),
          64'(seqs[k]), 64'(k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
